instr_prefetch_unit: RTL and testbench

- Sits directly downstream of ProgramMemory_SPI, between it and the CPU decode stage.
- Drives the memory address and tracks the memory's `ready` handshake (ready drops after an address change, rises when the instruction is valid).
- Prefetches sequential 16-bit instructions into a small tagged FIFO.
- Presents a valid/ready instruction stream with PC tags to decode; a redirect (jump/branch) flushes the FIFO and restarts fetch.

---
 rtl/prefetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_prefetch_unit.sv | 118 +++++++++++
 tb/tb_instr_prefetch_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types for the instruction prefetch unit: fetch FSM states and the
// tagged FIFO entry pairing an instruction with the address it was fetched from.
package prefetch_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT_DROP,
    S_WAIT_DATA
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead synchronous FIFO of tagged instructions with a synchronous flush.
// The head reads as zero while the FIFO is empty.
module fetch_fifo
  import prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          head_valid,
  output logic [CntW-1:0] count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q < CntW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_valid = (count_q != '0);
  assign head       = head_valid ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Sequential instruction prefetcher between the SPI program memory and decode.
// One fetch in flight at a time; a redirect flushes the FIFO and restarts fetch.
module instr_prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int unsigned       DEPTH        = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = 16'h0000,
  parameter int unsigned       DROP_TIMEOUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_instr,
  input  logic               mem_ready,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               fetch_busy
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned DropW = $clog2(DROP_TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DropW-1:0]  drop_cnt_q, drop_cnt_d;
  logic              capture;
  logic [CntW-1:0]   fifo_count;
  fetch_entry_t      push_entry, head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_WAIT_DROP;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    capture    = 1'b0;

    case (state_q)
      // Issuing only with a free slot guarantees the in-flight fetch can land.
      S_ISSUE: begin
        if (fifo_count < CntW'(DEPTH)) begin
          mem_addr_d = fetch_pc_q;
          drop_cnt_d = '0;
          state_d    = S_WAIT_DROP;
        end
      end
      // A ready that never falls means the address did not change; trust it
      // after the timeout.
      S_WAIT_DROP: begin
        if (!mem_ready) begin
          state_d = S_WAIT_DATA;
        end else if (drop_cnt_q == DropW'(DROP_TIMEOUT - 1)) begin
          capture = 1'b1;
        end else begin
          drop_cnt_d = drop_cnt_q + DropW'(1);
        end
      end
      S_WAIT_DATA: begin
        if (mem_ready) capture = 1'b1;
      end
      default: state_d = S_WAIT_DROP;
    endcase

    if (capture) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      state_d    = S_ISSUE;
    end

    // Redirect wins over everything, abandoning any in-flight fetch.
    if (redirect_valid) begin
      capture    = 1'b0;
      fetch_pc_d = redirect_pc;
      mem_addr_d = redirect_pc;
      drop_cnt_d = '0;
      state_d    = S_WAIT_DROP;
    end
  end

  assign push_entry = '{pc: fetch_pc_q, instr: mem_instr};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (capture),
    .push_entry (push_entry),
    .pop        (instr_ready),
    .head       (head),
    .head_valid (instr_valid),
    .count      (fifo_count)
  );

  assign mem_addr   = mem_addr_q;
  assign instr_data = head.instr;
  assign instr_pc   = head.pc;
  assign fetch_busy = (state_q == S_WAIT_DROP) || (state_q == S_WAIT_DATA);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Randomized bench for instr_prefetch_unit: a latency-modelled program memory
// and an in-order scoreboard of expected (pc, instruction) pairs.
module tb_instr_prefetch_unit;

  localparam int unsigned     DEPTH        = 4;
  localparam logic [15:0]     RESET_PC     = 16'h1234;
  localparam int unsigned     DROP_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_instr;
  logic        mem_ready;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        fetch_busy;

  int n_vec = 0;
  int n_err = 0;
  int pops  = 0;
  logic [15:0] exp_pc = RESET_PC;

  always #5 clk = ~clk;

  instr_prefetch_unit #(
    .DEPTH        (DEPTH),
    .RESET_PC     (RESET_PC),
    .DROP_TIMEOUT (DROP_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_instr      (mem_instr),
    .mem_ready      (mem_ready),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_busy     (fetch_busy)
  );

  function automatic logic [15:0] mem_func(input logic [15:0] a);
    case (a)
      16'h1234: return 16'hABCD;
      16'h1235: return 16'h5566;
      16'h9000: return 16'hDEAD;
      default:  return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endcase
  endfunction

  // Program memory: ready drops as soon as the address differs from the one
  // last served, and the new word arrives mem_lat+1 clocks later.
  logic [15:0] served_addr = 16'h0000;
  int unsigned mem_lat = 4;
  int unsigned lat_cnt = 0;

  always @(posedge clk) begin
    if (mem_addr != served_addr) begin
      if (lat_cnt >= mem_lat) begin
        served_addr <= mem_addr;
        lat_cnt     <= 0;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  assign mem_ready = (mem_addr == served_addr);
  assign mem_instr = mem_ready ? mem_func(served_addr) : 16'h0BAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, score any handshake, return just after posedge.
  task automatic cycle(input logic rdy, input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    if (redir) begin
      exp_pc = rpc;
    end else if (instr_valid && rdy) begin
      check("sb_pc", {16'h0, instr_pc}, {16'h0, exp_pc});
      check("sb_data", {16'h0, instr_data}, {16'h0, mem_func(exp_pc)});
      exp_pc = exp_pc + 16'd1;
      pops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 64) begin
      cycle(1'b0, 1'b0, 16'h0000);
      n++;
    end
    check(tag, {31'h0, instr_valid}, 32'd1);
  endtask

  initial begin
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", {31'h0, instr_valid}, 32'd0);
    check("rst_data", {16'h0, instr_data}, 32'h0);
    check("rst_pc", {16'h0, instr_pc}, 32'h0);
    check("rst_addr", {16'h0, mem_addr}, {16'h0, RESET_PC});
    check("rst_busy", {31'h0, fetch_busy}, 32'd1);
    rst = 1'b1;
    exp_pc = RESET_PC;

    // Cold start
    wait_valid("cold_wait0");
    check("cold_pc0", {16'h0, instr_pc}, 32'h1234);
    check("cold_data0", {16'h0, instr_data}, 32'hABCD);
    cycle(1'b1, 1'b0, 16'h0000);
    wait_valid("cold_wait1");
    check("cold_pc1", {16'h0, instr_pc}, 32'h1235);
    check("cold_data1", {16'h0, instr_data}, 32'h5566);
    cycle(1'b1, 1'b0, 16'h0000);
    n = 0;
    while (mem_addr != 16'h1236 && n < 32) begin
      cycle(1'b1, 1'b0, 16'h0000);
      n++;
    end
    check("cold_addr", {16'h0, mem_addr}, 32'h1236);

    // Redirect while waiting on data for 1236
    cycle(1'b1, 1'b0, 16'h0000);
    check("wd_busy", {31'h0, fetch_busy && !mem_ready}, 32'd1);
    cycle(1'b1, 1'b1, 16'h9000);
    check("redir_flush", {31'h0, instr_valid}, 32'd0);
    check("redir_addr", {16'h0, mem_addr}, 32'h9000);
    wait_valid("redir_wait");
    check("redir_pc", {16'h0, instr_pc}, 32'h9000);
    check("redir_data", {16'h0, instr_data}, 32'hDEAD);
    cycle(1'b1, 1'b0, 16'h0000);

    // Backpressure: the FIFO fills to DEPTH and fetch stalls on the last address
    mem_lat = 1;
    cycle(1'b0, 1'b1, 16'h1234);
    repeat (60) cycle(1'b0, 1'b0, 16'h0000);
    check("bp_addr", {16'h0, mem_addr}, 32'h1237);
    check("bp_busy", {31'h0, fetch_busy}, 32'd0);
    repeat (10) cycle(1'b0, 1'b0, 16'h0000);
    check("bp_addr_hold", {16'h0, mem_addr}, 32'h1237);
    for (int i = 0; i < int'(DEPTH); i++) begin
      check("bp_drain_pc", {16'h0, instr_pc}, 32'h1234 + i);
      cycle(1'b1, 1'b0, 16'h0000);
    end
    wait_valid("bp_resume_wait");
    check("bp_resume_pc", {16'h0, instr_pc}, 32'h1238);

    // Redirect to the address already on the bus: timeout path captures it
    cycle(1'b0, 1'b1, 16'h1234);
    repeat (60) cycle(1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 16'h1237);
    n = 0;
    while (!instr_valid && n < 20) begin
      cycle(1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("to_cycles", n, DROP_TIMEOUT);
    check("to_pc", {16'h0, instr_pc}, 32'h1237);
    cycle(1'b1, 1'b0, 16'h0000);

    // Address wrap
    cycle(1'b1, 1'b1, 16'hFFFF);
    wait_valid("wrap_wait0");
    check("wrap_pc0", {16'h0, instr_pc}, 32'hFFFF);
    cycle(1'b1, 1'b0, 16'h0000);
    wait_valid("wrap_wait1");
    check("wrap_pc1", {16'h0, instr_pc}, 32'h0000);
    cycle(1'b1, 1'b0, 16'h0000);

    // Asynchronous reset in the middle of a fetch
    mem_lat = 4;
    cycle(1'b0, 1'b1, 16'h4000);
    wait_valid("ar_wait");
    n = 0;
    while (!(fetch_busy && !mem_ready) && n < 20) begin
      cycle(1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("ar_midfetch", {31'h0, fetch_busy && !mem_ready}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", {31'h0, instr_valid}, 32'd0);
    check("ar_addr", {16'h0, mem_addr}, {16'h0, RESET_PC});
    check("ar_pc", {16'h0, instr_pc}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_pc = RESET_PC;
    wait_valid("ar_refetch_wait");
    check("ar_refetch_pc", {16'h0, instr_pc}, {16'h0, RESET_PC});
    check("ar_refetch_data", {16'h0, instr_data}, 32'hABCD);

    // Random traffic
    pops = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 63) == 0) mem_lat = $urandom_range(0, 5);
      if ($urandom_range(0, 39) == 0) begin
        cycle($urandom_range(0, 1) == 1, 1'b1, 16'($urandom));
      end else begin
        cycle($urandom_range(0, 3) != 0, 1'b0, 16'h0000);
      end
    end
    check("rand_progress", {31'h0, pops > 100}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
